// File: rtl/multi_debouncer.sv
// rtl/multi_debouncer.sv - multi-channel symmetric debouncer with rise/fall and optional auto-repeat pulses
//
// Optional feature: define DEBOUNCE_REPEAT_EN to build the per-channel auto-repeat counters.
//
// Ports:
//   clk       system clock
//   rst       asynchronous, active-high reset
//   i_signal  [N_CH] raw asynchronous inputs, one bit per channel
//   o_level   [N_CH] debounced level
//   o_rise    [N_CH] one-cycle pulse on o_level 0->1
//   o_fall    [N_CH] one-cycle pulse on o_level 1->0
//   o_rpt     [N_CH] auto-repeat pulse while held high (0 without DEBOUNCE_REPEAT_EN)
module multi_debouncer #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 25,
  parameter int CNTMAX      = 2500000,
  parameter int SYNC_STAGES = 2,
  parameter int REPEAT_MAX  = 62500000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i_signal,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall,
  output logic [N_CH-1:0] o_rpt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNTMAX - 1);
  localparam logic [26:0]      RPT_LAST = 27'(REPEAT_MAX - 1);

  if (N_CH < 1 || SYNC_STAGES < 2 || CNTMAX < 1 ||
      longint'(CNTMAX) >= (longint'(1) << CNT_W)) begin : g_bad_cfg
    $error("multi_debouncer: invalid N_CH, SYNC_STAGES or CNTMAX");
  end
  if (REPEAT_MAX < 1 || REPEAT_MAX >= (1 << 27)) begin : g_bad_rpt
    $error("multi_debouncer: invalid REPEAT_MAX");
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_ff;
    logic [CNT_W-1:0]       cnt;
    logic                   level;
    logic                   rise;
    logic                   fall;
    logic                   sync;
    logic                   accept;

    assign sync = sync_ff[SYNC_STAGES-1];
    // Change is accepted on the CNTMAX-th consecutive cycle that sync differs
    // from the current level; the sync value of that very cycle is taken.
    assign accept = (sync != level) && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_ff <= '0;
        cnt     <= '0;
        level   <= 1'b0;
        rise    <= 1'b0;
        fall    <= 1'b0;
      end else begin
        sync_ff <= {sync_ff[SYNC_STAGES-2:0], i_signal[c]};
        rise    <= accept & sync;
        fall    <= accept & ~sync;
        if (accept) begin
          level <= sync;
        end
        // Any cycle agreeing with the level discards the partial count.
        if (sync == level || accept) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    assign o_level[c] = level;
    assign o_rise[c]  = rise;
    assign o_fall[c]  = fall;

`ifdef DEBOUNCE_REPEAT_EN
    logic [26:0] rpt;
    logic        rpt_pulse;
    logic        level_next;

    // Looking at the next level lets a fall cancel a coincident repeat pulse.
    assign level_next = accept ? sync : level;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rpt       <= '0;
        rpt_pulse <= 1'b0;
      end else begin
        rpt_pulse <= 1'b0;
        if (!level_next || !level) begin
          rpt <= '0;
        end else if (rpt == RPT_LAST) begin
          rpt       <= '0;
          rpt_pulse <= 1'b1;
        end else begin
          rpt <= rpt + 27'd1;
        end
      end
    end

    assign o_rpt[c] = rpt_pulse;
`else
    assign o_rpt[c] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// tb/tb_multi_debouncer.sv - self-checking bench for multi_debouncer
module tb_multi_debouncer;

  localparam int N_CH   = 4;
  localparam int CNT_W  = 8;
  localparam int CNTMAX = 4;
  localparam int SYNC   = 2;
  localparam int RPT    = 5;
`ifdef DEBOUNCE_REPEAT_EN
  localparam bit RPT_ON = 1'b1;
`else
  localparam bit RPT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] i_signal = 4'b0;
  logic [3:0] o_level;
  logic [3:0] o_rise;
  logic [3:0] o_fall;
  logic [3:0] o_rpt;

  multi_debouncer #(
    .N_CH(N_CH), .CNT_W(CNT_W), .CNTMAX(CNTMAX),
    .SYNC_STAGES(SYNC), .REPEAT_MAX(RPT)
  ) dut (
    .clk(clk), .rst(rst), .i_signal(i_signal),
    .o_level(o_level), .o_rise(o_rise), .o_fall(o_fall), .o_rpt(o_rpt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] rpt;
  } exp_t;

  typedef struct {
    logic [3:0] sig;
    int         cycles;
    logic [3:0] level;
  } vec_t;

  exp_t       sb_q[$];
  logic [3:0] hist[$];
  logic [3:0] m_level;
  int         m_held[4];
  int         n_checks = 0;
  int         n_fail = 0;
  vec_t       vecs[11];

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a channel flips when the CNTMAX raw samples taken SYNC edges
  // ago and earlier all disagree with its current level.
  task automatic model_step(input logic [3:0] sig, output exp_t e);
    e = '{default: 4'b0};
    hist.push_front(sig);
    if (hist.size() > SYNC + CNTMAX) void'(hist.pop_back());
    for (int c = 0; c < N_CH; c++) begin
      logic old_l;
      logic new_l;
      logic v;
      bit   diff;
      old_l = m_level[c];
      diff  = 1'b1;
      for (int i = SYNC; i < SYNC + CNTMAX; i++) begin
        v = (i < hist.size()) ? hist[i][c] : 1'b0;
        if (v == old_l) diff = 1'b0;
      end
      new_l = diff ? ~old_l : old_l;
      e.level[c] = new_l;
      e.rise[c]  = new_l & ~old_l;
      e.fall[c]  = ~new_l & old_l;
      if (!new_l || !old_l) begin
        m_held[c] = 0;
      end else begin
        m_held[c]++;
        if (m_held[c] % RPT == 0) e.rpt[c] = RPT_ON;
      end
      m_level[c] = new_l;
    end
  endtask

  task automatic drive(input logic [3:0] sig);
    exp_t e;
    exp_t got;
    i_signal = sig;
    model_step(sig, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check4("sb_level", o_level, got.level);
    check4("sb_rise", o_rise, got.rise);
    check4("sb_fall", o_fall, got.fall);
    check4("sb_rpt", o_rpt, got.rpt);
  endtask

  task automatic do_reset(input logic [3:0] sig);
    i_signal = sig;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check4("rst_level", o_level, 4'b0);
      check4("rst_rise", o_rise, 4'b0);
      check4("rst_fall", o_fall, 4'b0);
      check4("rst_rpt", o_rpt, 4'b0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    hist.delete();
    m_level = 4'b0;
    for (int c = 0; c < N_CH; c++) m_held[c] = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise_edge;
    int rise_cnt;
    int fall_edge;
    int fall_cnt;
    int rpt_cnt;

    vecs[0]  = '{4'b0001, 5, 4'b0000};
    vecs[1]  = '{4'b0001, 1, 4'b0001};
    vecs[2]  = '{4'b0011, 3, 4'b0001};
    vecs[3]  = '{4'b0001, 8, 4'b0001};
    vecs[4]  = '{4'b0011, 5, 4'b0001};
    vecs[5]  = '{4'b0011, 1, 4'b0011};
    vecs[6]  = '{4'b0111, 6, 4'b0111};
    vecs[7]  = '{4'b0000, 5, 4'b0111};
    vecs[8]  = '{4'b0000, 1, 4'b0000};
    vecs[9]  = '{4'b1010, 6, 4'b1010};
    vecs[10] = '{4'b0101, 6, 4'b0101};

    // Reset with all inputs high, then a single rise 6 edges after release.
    do_reset(4'hF);
    rise_edge = -1;
    rise_cnt  = 0;
    for (int e = 0; e < 8; e++) begin
      drive(4'hF);
      if (o_rise == 4'hF && rise_edge < 0) rise_edge = e;
      if (o_rise != 4'b0) rise_cnt++;
    end
    check_int("reset_rise_edge", rise_edge, 5);
    check_int("reset_rise_count", rise_cnt, 1);

    for (int e = 0; e < 10; e++) drive(4'h0);
    check4("all_low_level", o_level, 4'b0000);

    // Press, glitch, exact-latency and release vectors.
    foreach (vecs[k]) begin
      for (int n = 0; n < vecs[k].cycles; n++) drive(vecs[k].sig);
      check4($sformatf("vec%0d_level", k), o_level, vecs[k].level);
    end

    // Release bounce on ch2: 1-cycle highs every 2 cycles, then low.
    fall_edge = -1;
    fall_cnt  = 0;
    for (int e = 0; e < 30; e++) begin
      drive((e < 20 && (e % 2) == 1) ? 4'b0101 : 4'b0001);
      if (o_fall[2]) begin
        fall_cnt++;
        fall_edge = e;
      end
    end
    check_int("bounce_fall_count", fall_cnt, 1);
    check_int("bounce_fall_edge", fall_edge, 25);

    // Concurrent rise on ch0 and fall on ch3.
    for (int e = 0; e < 10; e++) drive(4'b1000);
    for (int e = 0; e < 6; e++) drive(4'b0001);
    check4("conc_rise", o_rise, 4'b0001);
    check4("conc_fall", o_fall, 4'b1000);

    // Reset mid-count discards progress.
    for (int e = 0; e < 3; e++) drive(4'b0011);
    do_reset(4'b0011);
    rise_edge = -1;
    for (int e = 0; e < 8; e++) begin
      drive(4'b0011);
      if (o_rise == 4'b0011 && rise_edge < 0) rise_edge = e;
    end
    check_int("midreset_rise_edge", rise_edge, 5);

    // Auto-repeat on ch0; the fall lands where a 4th repeat would be.
    for (int e = 0; e < 10; e++) drive(4'b0000);
    rpt_cnt = 0;
    for (int e = 0; e < 35; e++) begin
      drive(e < 20 ? 4'b0001 : 4'b0000);
      if (o_rpt[0]) begin
        check_int($sformatf("rpt_edge%0d", rpt_cnt), e, 10 + 5 * rpt_cnt);
        rpt_cnt++;
      end
    end
    check_int("rpt_count", rpt_cnt, RPT_ON ? 3 : 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
